// File: rtl/mips_ifu_pkg.sv
// Shared types and constants for the MIPS instruction fetch unit.
// The FAULT state is only reachable when IFU_ADDR_CHECK_EN is defined.
package mips_ifu_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
    } if_slot_t;

endpackage

// File: rtl/ifu_addr_map.sv
// Maps a byte PC onto the instruction-memory word index and flags PCs
// that are misaligned or fall outside the IM window.
module ifu_addr_map
    import mips_ifu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          IM_WORDS = 1024
) (
    input  logic [31:0] pc_i,
    output logic [31:0] instr_addr_o,
    output logic        fault_o
);

    localparam int AW = $clog2(IM_WORDS);

    logic [31:0] offset;

    // Unsigned subtraction: PCs below PC_RESET wrap to large offsets.
    assign offset       = pc_i - PC_RESET;
    assign instr_addr_o = {{(32 - AW){1'b0}}, offset[AW+1:2]};
    assign fault_o      = (pc_i[1:0] != 2'b00) ||
                          (pc_i < PC_RESET) ||
                          (offset[31:AW+2] != '0);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC register, IM requester and registered IF slot
// with valid/ready towards decode. Address checking under IFU_ADDR_CHECK_EN.
module ifu_fetch
    import mips_ifu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] Instr_Addr,
    input  logic [31:0] Instruction,
    input  logic        Redirect_Valid,
    input  logic [31:0] Redirect_PC,
    input  logic        IF_Ready,
    output logic        IF_Valid,
    output logic [31:0] IF_Instr,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PC8,
    output logic [31:0] Fetch_Count
`ifdef IFU_ADDR_CHECK_EN
    ,
    output logic        Fetch_Error
`endif
);

    ifu_state_e  state_q, state_d;
    if_slot_t    slot_q, slot_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic        advance, handshake, fetch_ok;

`ifdef IFU_ADDR_CHECK_EN
    logic        err_q, err_d;
    logic        pc_fault;

    ifu_addr_map #(.PC_RESET(PC_RESET), .IM_WORDS(IM_WORDS)) u_addr_map (
        .pc_i         (pc_q),
        .instr_addr_o (Instr_Addr),
        .fault_o      (pc_fault)
    );

    assign fetch_ok = !pc_fault;
`else
    logic        pc_fault_unused;

    ifu_addr_map #(.PC_RESET(PC_RESET), .IM_WORDS(IM_WORDS)) u_addr_map (
        .pc_i         (pc_q),
        .instr_addr_o (Instr_Addr),
        .fault_o      (pc_fault_unused)
    );

    assign fetch_ok = 1'b1;
`endif

    assign advance   = !slot_q.valid || IF_Ready;
    assign handshake = slot_q.valid && IF_Ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RUN;
            pc_q    <= PC_RESET;
            slot_q  <= '0;
            count_q <= '0;
`ifdef IFU_ADDR_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            slot_q  <= slot_d;
            count_q <= count_d;
`ifdef IFU_ADDR_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef IFU_ADDR_CHECK_EN
        if (state_q == RUN && !Redirect_Valid && advance && pc_fault) begin
            state_d = FAULT;
        end
`endif
    end

    always_comb begin
        pc_d    = pc_q;
        slot_d  = slot_q;
        count_d = count_q;
`ifdef IFU_ADDR_CHECK_EN
        err_d   = err_q;
`endif
        if (state_q == RUN) begin
            // A handshake coinciding with a redirect still consumed the slot.
            if (handshake) begin
                count_d = count_q + 32'd1;
            end
            if (Redirect_Valid) begin
                pc_d         = Redirect_PC;
                slot_d.valid = 1'b0;
            end else if (advance) begin
                if (fetch_ok) begin
                    slot_d.valid = 1'b1;
                    slot_d.instr = Instruction;
                    slot_d.pc    = pc_q;
                    pc_d         = pc_q + 32'd4;
                end else begin
                    slot_d.valid = 1'b0;
`ifdef IFU_ADDR_CHECK_EN
                    err_d        = 1'b1;
`endif
                end
            end
        end else begin
            slot_d.valid = 1'b0;
        end
    end

    assign IF_Valid    = slot_q.valid;
    assign IF_Instr    = slot_q.instr;
    assign IF_PC       = slot_q.pc;
    assign IF_PC8      = slot_q.pc + 32'd8;
    assign Fetch_Count = count_q;
`ifdef IFU_ADDR_CHECK_EN
    assign Fetch_Error = err_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: directed stimulus pushes expected handshakes,
// a monitor pops them whenever decode accepts the IF slot.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] Instr_Addr;
    logic [31:0] Instruction;
    logic        Redirect_Valid;
    logic [31:0] Redirect_PC;
    logic        IF_Ready;
    logic        IF_Valid;
    logic [31:0] IF_Instr;
    logic [31:0] IF_PC;
    logic [31:0] IF_PC8;
    logic [31:0] Fetch_Count;
`ifdef IFU_ADDR_CHECK_EN
    logic        Fetch_Error;
`endif

    always #5 clk = ~clk;

    ifu_fetch #(.PC_RESET(32'h0000_3000), .IM_WORDS(1024)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .Instr_Addr     (Instr_Addr),
        .Instruction    (Instruction),
        .Redirect_Valid (Redirect_Valid),
        .Redirect_PC    (Redirect_PC),
        .IF_Ready       (IF_Ready),
        .IF_Valid       (IF_Valid),
        .IF_Instr       (IF_Instr),
        .IF_PC          (IF_PC),
        .IF_PC8         (IF_PC8),
        .Fetch_Count    (Fetch_Count)
`ifdef IFU_ADDR_CHECK_EN
        ,
        .Fetch_Error    (Fetch_Error)
`endif
    );

    // Word 0 is the hand-picked ori instruction; other words carry their index.
    function automatic logic [31:0] inst(input int i);
        return (i == 0) ? 32'h3401_0001 : (32'hA500_0000 | 32'(i));
    endfunction

    logic [31:0] im [0:1023];
    assign Instruction = im[Instr_Addr[9:0]];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input int idx);
        exp_t e;
        e.pc    = pc;
        e.instr = inst(idx);
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && IF_Valid && IF_Ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual_pc=%h expected=none", IF_PC);
                end else begin
                    e = sb.pop_front();
                    chk("sb_pc", IF_PC, e.pc);
                    chk("sb_instr", IF_Instr, e.instr);
                    chk("sb_pc8", IF_PC8, e.pc + 32'd8);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) im[i] = inst(i);
        reset_n        = 1'b0;
        IF_Ready       = 1'b0;
        Redirect_Valid = 1'b0;
        Redirect_PC    = 32'h0;
        cyc();
        cyc();
        chk("rst_valid", {31'b0, IF_Valid}, 32'd0);
        chk("rst_instr", IF_Instr, 32'h0);
        chk("rst_pc", IF_PC, 32'h0);
        chk("rst_pc8", IF_PC8, 32'h8);
        chk("rst_count", Fetch_Count, 32'd0);
        chk("rst_addr", Instr_Addr, 32'd0);
`ifdef IFU_ADDR_CHECK_EN
        chk("rst_err", {31'b0, Fetch_Error}, 32'd0);
`endif
        $display("txn reset: checked reset state");

        push(32'h3000, 0);
        push(32'h3004, 1);
        push(32'h3008, 2);
        push(32'h300C, 3);
        reset_n  = 1'b1;
        IF_Ready = 1'b1;
        cyc();
        chk("rel_valid", {31'b0, IF_Valid}, 32'd1);
        chk("rel_pc", IF_PC, 32'h3000);
        chk("rel_pc8", IF_PC8, 32'h3008);
        chk("rel_instr", IF_Instr, 32'h3401_0001);
        chk("rel_addr", Instr_Addr, 32'd1);
        $display("txn release: IF_PC=%h IF_Instr=%h", IF_PC, IF_Instr);
        cyc();
        chk("s1_pc", IF_PC, 32'h3004);
        chk("s1_count", Fetch_Count, 32'd1);

        IF_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_valid", {31'b0, IF_Valid}, 32'd1);
            chk("stall_pc", IF_PC, 32'h3004);
            chk("stall_instr", IF_Instr, inst(1));
            chk("stall_addr", Instr_Addr, 32'd2);
            chk("stall_count", Fetch_Count, 32'd1);
            $display("txn stall %0d: IF_PC=%h count=%0d", i, IF_PC, Fetch_Count);
        end

        IF_Ready = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        chk("stream_count", Fetch_Count, 32'd4);
        chk("stream_pc", IF_PC, 32'h3010);
        $display("txn stream: count=%0d IF_PC=%h", Fetch_Count, IF_PC);

        push(32'h3010, 4);
        push(32'h3040, 16);
        Redirect_Valid = 1'b1;
        Redirect_PC    = 32'h3040;
        cyc();
        chk("redir_valid", {31'b0, IF_Valid}, 32'd0);
        chk("redir_count", Fetch_Count, 32'd5);
        chk("redir_addr", Instr_Addr, 32'd16);
        Redirect_Valid = 1'b0;
        cyc();
        chk("redir_tgt_valid", {31'b0, IF_Valid}, 32'd1);
        chk("redir_tgt_pc", IF_PC, 32'h3040);
        chk("redir_tgt_instr", IF_Instr, inst(16));
        chk("redir_tgt_addr", Instr_Addr, 32'd17);
        cyc();
        chk("redir_after_count", Fetch_Count, 32'd6);
        chk("redir_after_pc", IF_PC, 32'h3044);
        IF_Ready = 1'b0;
        $display("txn redirect: count=%0d IF_PC=%h", Fetch_Count, IF_PC);

        Redirect_Valid = 1'b1;
        Redirect_PC    = 32'h3080;
        cyc();
        chk("b2b1_valid", {31'b0, IF_Valid}, 32'd0);
        Redirect_PC = 32'h3100;
        cyc();
        chk("b2b2_valid", {31'b0, IF_Valid}, 32'd0);
        chk("b2b2_addr", Instr_Addr, 32'd64);
        Redirect_Valid = 1'b0;
        cyc();
        chk("b2b_valid", {31'b0, IF_Valid}, 32'd1);
        chk("b2b_pc", IF_PC, 32'h3100);
        chk("b2b_instr", IF_Instr, inst(64));
        chk("b2b_count", Fetch_Count, 32'd6);
        $display("txn back-to-back redirect: IF_PC=%h", IF_PC);

        Redirect_Valid = 1'b1;
        Redirect_PC    = 32'h3200;
        reset_n        = 1'b0;
        cyc();
        chk("mrst_valid", {31'b0, IF_Valid}, 32'd0);
        chk("mrst_instr", IF_Instr, 32'h0);
        chk("mrst_pc", IF_PC, 32'h0);
        chk("mrst_pc8", IF_PC8, 32'h8);
        chk("mrst_count", Fetch_Count, 32'd0);
        chk("mrst_addr", Instr_Addr, 32'd0);
        reset_n        = 1'b1;
        Redirect_Valid = 1'b0;
        cyc();
        chk("mrst_next_valid", {31'b0, IF_Valid}, 32'd1);
        chk("mrst_next_pc", IF_PC, 32'h3000);
        $display("txn reset mid-stall: IF_PC=%h", IF_PC);

        Redirect_Valid = 1'b1;
        Redirect_PC    = 32'h3002;
        cyc();
        chk("mis_valid", {31'b0, IF_Valid}, 32'd0);
        chk("mis_addr", Instr_Addr, 32'd0);
        Redirect_Valid = 1'b0;
        cyc();
`ifdef IFU_ADDR_CHECK_EN
        chk("fault_err", {31'b0, Fetch_Error}, 32'd1);
        chk("fault_valid", {31'b0, IF_Valid}, 32'd0);
        Redirect_Valid = 1'b1;
        Redirect_PC    = 32'h3000;
        cyc();
        chk("fault_redir_valid", {31'b0, IF_Valid}, 32'd0);
        Redirect_Valid = 1'b0;
        cyc();
        chk("fault_hold_valid", {31'b0, IF_Valid}, 32'd0);
        chk("fault_hold_err", {31'b0, Fetch_Error}, 32'd1);
        chk("fault_hold_count", Fetch_Count, 32'd0);
        chk("fault_hold_addr", Instr_Addr, 32'd0);
        $display("txn fault: Fetch_Error=%0d IF_Valid=%0d", Fetch_Error, IF_Valid);
        reset_n = 1'b0;
        cyc();
        chk("fault_rst_err", {31'b0, Fetch_Error}, 32'd0);
        reset_n = 1'b1;
        cyc();
        chk("fault_rst_pc", IF_PC, 32'h3000);
`else
        chk("mis_fetch_valid", {31'b0, IF_Valid}, 32'd1);
        chk("mis_fetch_pc", IF_PC, 32'h3002);
        chk("mis_fetch_instr", IF_Instr, inst(0));
        chk("mis_fetch_pc8", IF_PC8, 32'h300A);
        chk("mis_next_addr", Instr_Addr, 32'd1);
        $display("txn misaligned fetch: IF_PC=%h", IF_PC);
        Redirect_Valid = 1'b1;
        Redirect_PC    = 32'h2FFC;
        cyc();
        chk("wrap_addr", Instr_Addr, 32'd1023);
        Redirect_Valid = 1'b0;
        cyc();
        chk("wrap_pc", IF_PC, 32'h2FFC);
        chk("wrap_instr", IF_Instr, inst(1023));
        $display("txn below-base wrap: IF_PC=%h IF_Instr=%h", IF_PC, IF_Instr);
`endif

        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit for the single-cycle/pipelined MIPS core: owns the PC register and drives the combinational instruction memory (IM) through `Instr_Addr`/`Instruction`. It is the requester end of the IM read interface. Each fetched word is registered into an IF output slot with a valid/ready handshake towards decode. Redirects (branch/jump/jr) come back from later stages.

## Interface
- `PC_RESET`, 32'h0000_3000, byte PC loaded on reset.
- `IM_WORDS`, 1024, IM depth in 32-bit words; power of two.
- `clk` in 1, sole clock; all state updates on rising edge.
- `reset_n` in 1, synchronous, active-low reset.
- `Instr_Addr` out 32, IM word index = (PC − PC_RESET) >> 2, reduced modulo IM_WORDS.
- `Instruction` in 32, IM read data; combinational from `Instr_Addr` in the same cycle.
- `Redirect_Valid` in 1, load `Redirect_PC` as next PC and flush the IF slot.
- `Redirect_PC` in 32, redirect target byte PC.
- `IF_Ready` in 1, decode accepts the IF slot this cycle.
- `IF_Valid` out 1, IF slot holds a valid instruction.
- `IF_Instr` out 32, fetched instruction word.
- `IF_PC` out 32, byte PC of `IF_Instr`.
- `IF_PC8` out 32, `IF_PC` + 8 (link value for jal/jalr).
- `Fetch_Count` out 32, number of accepted handshakes (IF_Valid & IF_Ready); wraps at 2^32.
- `Fetch_Error` out 1, sticky fault flag; exists only with IFU_ADDR_CHECK_EN.

## Operation
- **Registers:** PC, IF slot (`IF_Valid`, `IF_Instr`, `IF_PC`), `Fetch_Count`, and the state machine.
- **States:** RUN and FAULT. FAULT exists only with the macro.
- **Reset** (reset_n low at an edge):
  - PC = PC_RESET.
  - `IF_Valid` = 0, `IF_Instr` = 0, `IF_PC` = 0, `IF_PC8` = 8.
  - `Fetch_Count` = 0, `Fetch_Error` = 0.
  - State = RUN.
- **Advance** = !IF_Valid | IF_Ready.
- **RUN, priority order:**
  1. **Redirect_Valid:**
     - PC ← Redirect_PC; IF_Valid ← 0.
     - If IF_Valid & IF_Ready in the same cycle, that handshake still counts; the slot content was consumed.
  2. **Advance:**
     - IF_Instr ← Instruction; IF_PC ← PC; IF_Valid ← 1.
     - PC ← PC + 4, 32-bit wrap.
  3. **Otherwise (stall):** PC and the IF slot hold their values.
- **Interface stability:**
  - `Instr_Addr` is always derived from the current PC, including during stall.
  - IM reads have no side effects, so re-reading during a stall is harmless.
- **Word index arithmetic:**
  - Unsigned 32-bit subtraction, then discard bits [1:0], then keep log2(IM_WORDS) LSBs.
  - Upper bits of `Instr_Addr` are zero.
- **Counter:** `Fetch_Count` increments on every cycle with IF_Valid & IF_Ready, including during a redirect.
- **FAULT:** see Configuration.

## Timing
- **Fetch latency:** one cycle. The word at PC appears on `IF_Instr` the cycle after the advancing edge.
- **First instruction:** with reset_n high at edge k+1 after a reset edge k, `IF_Valid` = 1 after edge k+1 with IF_PC = PC_RESET.
- **Throughput:** one instruction per cycle while IF_Ready = 1.
- **Redirect penalty:** one bubble.
  - Redirect sampled at edge e gives IF_Valid = 0 after e.
  - The instruction at Redirect_PC is valid after e+1, provided there is no further redirect.
- **Back-to-back redirects:** the last one wins; IF_Valid stays 0 until one clean cycle follows.
- **Handshake rule:** while IF_Valid = 1 and IF_Ready = 0, IF_Instr/IF_PC hold stable.
- **Reset mid-operation:** reset overrides redirect and stall on the same edge.

## Configuration
- **Macro:** `IFU_ADDR_CHECK_EN`.
- **Defined:**
  - A PC is faulting if PC[1:0] ≠ 0, PC < PC_RESET, or (PC − PC_RESET) >> 2 ≥ IM_WORDS.
  - When an advance would fetch a faulting PC: IF_Valid ← 0, Fetch_Error ← 1, state ← FAULT, PC holds.
  - In FAULT:
    - no fetches occur and IF_Valid stays 0;
    - redirects are ignored;
    - `Fetch_Count` is frozen;
    - only reset exits FAULT.
  - A redirect to a faulting PC takes effect normally; the fault is raised on the following advance.
- **Not defined:**
  - No check; the index wraps modulo IM_WORDS and PC[1:0] is ignored.
  - No `Fetch_Error` port and no FAULT state.

## Structure
- **Package `mips_ifu_pkg`:**
  - PC_RESET default constant;
  - state typedef (RUN, FAULT);
  - IF-slot struct typedef (valid, instr, pc).
- **Sub-module `ifu_addr_map`:** combinational PC → `Instr_Addr` index, plus the fault predicate (used only under the macro).
- Everything else lives in `ifu_fetch`.

## Test plan
- **Reset release:** IM[0] = 32'h3401_0001, IF_Ready = 1 → after the first clean edge, IF_Valid = 1, IF_PC = 32'h3000, IF_PC8 = 32'h3008, IF_Instr = 32'h3401_0001; Instr_Addr then reads 1.
- **Streaming:** IF_Ready = 1 for 4 cycles → IF_PC steps 3000/3004/3008/300C and Fetch_Count = 4 after 4 accepted handshakes.
- **Stall:** IF_Ready = 0 for 3 cycles with IF_PC = 32'h3004 → IF_Instr/IF_PC are constant, Instr_Addr stays 2, and Fetch_Count does not increment.
- **Redirect with handshake:**
  - stimulus: Redirect_Valid = 1, Redirect_PC = 32'h3040, IF_Valid = IF_Ready = 1;
  - Fetch_Count increments and IF_Valid = 0 for one cycle;
  - the next valid IF_PC = 32'h3040, with Instr_Addr = 16 during that fetch.
- **Reset mid-stall:** reset_n low while IF_Valid = 1, IF_Ready = 0, and a redirect is pending → all outputs at reset values and PC = 32'h3000 next cycle.
- **Fault:**
  - with IFU_ADDR_CHECK_EN: redirect to 32'h3002 → Fetch_Error = 1 after the next edge, IF_Valid stays 0, and a later redirect to 32'h3000 is ignored until reset;
  - without the macro: the same stimulus fetches index 0 with IF_PC = 32'h3002.
